sync_fifo_level: RTL and testbench

// Next-generation single-clock FIFO: circular buffer of 2^ADDR_WIDTH words with an occupancy

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/sync_fifo_level_if.sv | 33 +++
 rtl/fifo_dp_ram.sv | 33 +++
 rtl/sync_fifo_level.sv | 95 +++++++++
 tb/tb_sync_fifo_level.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: clog2, count-width sizing, and the FIFO_PARAM_CHECK legality macro
// that every FIFO variant expands once at module scope.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_PARAM_CHECK(aw, af, ae) \
  if ((aw) < 2 || (aw) > 16 || (af) < 1 || (af) > (1 << (aw)) || \
      (ae) < 0 || (ae) > (1 << (aw)) - 1) begin : g_param_check \
    $error("fifo: illegal ADDR_WIDTH/ALMOST_FULL/ALMOST_EMPTY combination"); \
  end

package fifo_pkg;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) res++;
    return res;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the address.
  function automatic int FIFO_COUNT_WIDTH(input int aw);
    return aw + 1;
  endfunction

endpackage

`endif

// File: rtl/sync_fifo_level_if.sv
// Producer/consumer bundle for sync_fifo_level; slave is the FIFO side, master the user side.
interface sync_fifo_level_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  import fifo_pkg::*;

  localparam int CW = FIFO_COUNT_WIDTH(ADDR_WIDTH);

  logic                  flush;
  logic                  clearErrors;
  logic                  writeEnable;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  full;
  logic                  almostFull;
  logic                  readEnable;
  logic [DATA_WIDTH-1:0] readData;
  logic                  empty;
  logic                  almostEmpty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  flush, clearErrors, writeEnable, writeData, readEnable,
    output full, almostFull, readData, empty, almostEmpty, count, overflow, underflow
  );

  modport master (
    output flush, clearErrors, writeEnable, writeData, readEnable,
    input  full, almostFull, readData, empty, almostEmpty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM: one write port, one read port that is either registered
// (cleared by reset, updated only on rdEn) or asynchronous, chosen by ASYNC_READ.
module fifo_dp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter bit ASYNC_READ = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0] rdData
);
  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  if (ASYNC_READ) begin : g_async
    logic unusedSyncCtrl;
    assign unusedSyncCtrl = reset | rdEn;
    assign rdData = mem[rdAddr];
  end else begin : g_sync
    always_ff @(posedge clock) begin
      if (reset)     rdData <= '0;
      else if (rdEn) rdData <= mem[rdAddr];
    end
  end
endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with occupancy count, registered level flags, flush and sticky errors.
// Define SYNC_FIFO_LEVEL_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_level
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 1
) (
  input logic              clock,
  input logic              reset,
  sync_fifo_level_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = FIFO_COUNT_WIDTH(ADDR_WIDTH);
`ifdef SYNC_FIFO_LEVEL_FWFT_EN
  localparam bit ASYNC_READ = 1'b1;
`else
  localparam bit ASYNC_READ = 1'b0;
`endif

  `FIFO_PARAM_CHECK(ADDR_WIDTH, ALMOST_FULL, ALMOST_EMPTY)

  logic [ADDR_WIDTH-1:0] wrPtr, rdPtr;
  logic [CW-1:0]         count, nextCount;
  logic                  full, empty, almostFull, almostEmpty;
  logic                  overflow, underflow;
  logic                  wrOk, rdOk, wrReject, rdReject;

  // Acceptance uses the registered (pre-edge) flags; flush swallows requests without errors.
  always_comb begin
    wrOk      = bus.writeEnable & ~full  & ~bus.flush;
    rdOk      = bus.readEnable  & ~empty & ~bus.flush;
    wrReject  = bus.writeEnable &  full  & ~bus.flush;
    rdReject  = bus.readEnable  &  empty & ~bus.flush;
    nextCount = count;
    if (bus.flush) nextCount = '0;
    else           nextCount = count + CW'(wrOk) - CW'(rdOk);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almostFull  <= (ALMOST_FULL == 0);
      almostEmpty <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (bus.flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (wrOk) wrPtr <= wrPtr + ADDR_WIDTH'(1);
        if (rdOk) rdPtr <= rdPtr + ADDR_WIDTH'(1);
      end
      count       <= nextCount;
      full        <= (nextCount == CW'(DEPTH));
      empty       <= (nextCount == '0);
      almostFull  <= (nextCount >= CW'(ALMOST_FULL));
      almostEmpty <= (nextCount <= CW'(ALMOST_EMPTY));
      if (bus.clearErrors) overflow  <= 1'b0;
      else if (wrReject)   overflow  <= 1'b1;
      if (bus.clearErrors) underflow <= 1'b0;
      else if (rdReject)   underflow <= 1'b1;
    end
  end

  fifo_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ASYNC_READ (ASYNC_READ)
  ) u_ram (
    .clock  (clock),
    .reset  (reset),
    .wrEn   (wrOk),
    .wrAddr (wrPtr),
    .wrData (bus.writeData),
    .rdEn   (rdOk),
    .rdAddr (rdPtr),
    .rdData (bus.readData)
  );

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostFull  = almostFull;
  assign bus.almostEmpty = almostEmpty;
  assign bus.count       = count;
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;
endmodule

// File: tb/tb_sync_fifo_level.sv
// Bench for sync_fifo_level: directed scenarios plus randomized traffic against a queue model.
module tb_sync_fifo_level;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sync_fifo_level_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  sync_fifo_level #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .ALMOST_FULL(6), .ALMOST_EMPTY(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0] mq[$];
  logic [7:0] mrd  = 8'h00;
  bit         movf = 1'b0;
  bit         munf = 1'b0;

  // Drive one cycle of requests, advance the reference queue, sample 1 time unit after the edge.
  task automatic step(input bit we, input logic [7:0] wd, input bit re,
                      input bit fl = 1'b0, input bit clr = 1'b0, input bit rs = 1'b0);
    bit mfull, mempty;
    reset = rs; bus.flush = fl; bus.clearErrors = clr;
    bus.writeEnable = we; bus.writeData = wd; bus.readEnable = re;
    mfull  = (mq.size() == DEPTH);
    mempty = (mq.size() == 0);
    if (rs) begin
      mq.delete(); mrd = 8'h00; movf = 1'b0; munf = 1'b0;
    end else begin
      if (clr) begin
        movf = 1'b0; munf = 1'b0;
      end else if (!fl) begin
        if (we && mfull)  movf = 1'b1;
        if (re && mempty) munf = 1'b1;
      end
      if (fl) mq.delete();
      else begin
        if (re && !mempty) mrd = mq.pop_front();
        if (we && !mfull)  mq.push_back(wd);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    nChecks++; if (bus.count !== 4'd0) begin nFails++; $display("FAIL reset count: got %0d want 0", bus.count); end
    nChecks++; if (bus.empty !== 1'b1) begin nFails++; $display("FAIL reset empty: got %b want 1", bus.empty); end
    nChecks++; if (bus.full !== 1'b0) begin nFails++; $display("FAIL reset full: got %b want 0", bus.full); end
    nChecks++; if (bus.almostFull !== 1'b0) begin nFails++; $display("FAIL reset almostFull: got %b want 0", bus.almostFull); end
    nChecks++; if (bus.almostEmpty !== 1'b1) begin nFails++; $display("FAIL reset almostEmpty: got %b want 1", bus.almostEmpty); end
    nChecks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin nFails++; $display("FAIL reset errors: got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow); end
`ifndef SYNC_FIFO_LEVEL_FWFT_EN
    nChecks++; if (bus.readData !== 8'h00) begin nFails++; $display("FAIL reset readData: got %h want 00", bus.readData); end
`endif
  endtask

  task automatic test_fill_drain();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0);
      nChecks++; if (bus.count !== 4'(i + 1)) begin nFails++; $display("FAIL fill count: got %0d want %0d", bus.count, i + 1); end
      nChecks++; if (bus.almostFull !== (i + 1 >= 6)) begin nFails++; $display("FAIL fill almostFull at %0d: got %b want %b", i + 1, bus.almostFull, (i + 1 >= 6)); end
      nChecks++; if (bus.full !== (i == DEPTH - 1)) begin nFails++; $display("FAIL fill full at %0d: got %b want %b", i + 1, bus.full, (i == DEPTH - 1)); end
    end
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_LEVEL_FWFT_EN
      nChecks++; if (bus.readData !== 8'(8'h10 + i)) begin nFails++; $display("FAIL drain data: got %h want %h", bus.readData, 8'(8'h10 + i)); end
      step(1'b0, 8'h00, 1'b1);
`else
      step(1'b0, 8'h00, 1'b1);
      nChecks++; if (bus.readData !== 8'(8'h10 + i)) begin nFails++; $display("FAIL drain data: got %h want %h", bus.readData, 8'(8'h10 + i)); end
`endif
      nChecks++; if (bus.count !== 4'(DEPTH - 1 - i)) begin nFails++; $display("FAIL drain count: got %0d want %0d", bus.count, DEPTH - 1 - i); end
    end
    nChecks++; if (bus.empty !== 1'b1 || bus.almostEmpty !== 1'b1) begin nFails++; $display("FAIL drain flags: got empty=%b almostEmpty=%b want 1 1", bus.empty, bus.almostEmpty); end
  endtask

  task automatic test_wrap();
    int seq[2] = '{5, 8};
    logic [7:0] exp, got;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    foreach (seq[k]) begin
      for (int i = 0; i < seq[k]; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < seq[k]; i++) begin
`ifdef SYNC_FIFO_LEVEL_FWFT_EN
        exp = mq[0]; got = bus.readData;
        step(1'b0, 8'h00, 1'b1);
`else
        step(1'b0, 8'h00, 1'b1);
        exp = mrd; got = bus.readData;
`endif
        nChecks++; if (got !== exp) begin nFails++; $display("FAIL wrap data pass %0d word %0d: got %h want %h", k, i, got, exp); end
      end
    end
    nChecks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.count !== 4'd0) begin nFails++; $display("FAIL wrap end: got ovf=%b unf=%b count=%0d want 0 0 0", bus.overflow, bus.underflow, bus.count); end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    nChecks++; if (bus.count !== 4'd7 || bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin nFails++; $display("FAIL rw at full: got count=%0d ovf=%b unf=%b want 7 1 0", bus.count, bus.overflow, bus.underflow); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h66, 1'b1);
    nChecks++; if (bus.count !== 4'd1 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin nFails++; $display("FAIL rw at empty: got count=%0d unf=%b ovf=%b want 1 1 0", bus.count, bus.underflow, bus.overflow); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    nChecks++; if (bus.count !== 4'd4 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin nFails++; $display("FAIL rw at 4: got count=%0d ovf=%b unf=%b want 4 0 0", bus.count, bus.overflow, bus.underflow); end
`ifndef SYNC_FIFO_LEVEL_FWFT_EN
    nChecks++; if (bus.readData !== 8'h66) begin nFails++; $display("FAIL rw at 4 data: got %h want 66", bus.readData); end
`endif
  endtask

  task automatic test_flush();
    logic [7:0] held;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    held = bus.readData;
    step(1'b1, 8'h99, 1'b1, 1'b1);
    nChecks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin nFails++; $display("FAIL flush state: got count=%0d empty=%b full=%b want 0 1 0", bus.count, bus.empty, bus.full); end
    nChecks++; if (bus.almostEmpty !== 1'b1 || bus.almostFull !== 1'b0) begin nFails++; $display("FAIL flush almost: got ae=%b af=%b want 1 0", bus.almostEmpty, bus.almostFull); end
    nChecks++; if (bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin nFails++; $display("FAIL flush errors: got ovf=%b unf=%b want 1 0", bus.overflow, bus.underflow); end
`ifndef SYNC_FIFO_LEVEL_FWFT_EN
    nChecks++; if (bus.readData !== held || held !== 8'h22) begin nFails++; $display("FAIL flush readData hold: got %h want 22", bus.readData); end
`endif
    step(1'b1, 8'hA5, 1'b0);
`ifdef SYNC_FIFO_LEVEL_FWFT_EN
    nChecks++; if (bus.readData !== 8'hA5) begin nFails++; $display("FAIL post-flush data: got %h want a5", bus.readData); end
    step(1'b0, 8'h00, 1'b1);
`else
    step(1'b0, 8'h00, 1'b1);
    nChecks++; if (bus.readData !== 8'hA5) begin nFails++; $display("FAIL post-flush data: got %h want a5", bus.readData); end
`endif
    nChecks++; if (bus.empty !== 1'b1) begin nFails++; $display("FAIL post-flush empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_errors();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'($urandom), 1'b0);
    nChecks++; if (bus.overflow !== 1'b1) begin nFails++; $display("FAIL overflow set: got %b want 1", bus.overflow); end
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    nChecks++; if (bus.overflow !== 1'b0 || bus.count !== 4'd8) begin nFails++; $display("FAIL clear beats overflow: got ovf=%b count=%0d want 0 8", bus.overflow, bus.count); end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1);
    nChecks++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin nFails++; $display("FAIL underflow set: got unf=%b ovf=%b want 1 0", bus.underflow, bus.overflow); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    nChecks++; if (bus.underflow !== 1'b0) begin nFails++; $display("FAIL clear beats underflow: got %b want 0", bus.underflow); end
  endtask

`ifdef SYNC_FIFO_LEVEL_FWFT_EN
  task automatic test_fwft();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    nChecks++; if (bus.readData !== 8'h3C || bus.empty !== 1'b0) begin nFails++; $display("FAIL fwft head: got data=%h empty=%b want 3c 0", bus.readData, bus.empty); end
    step(1'b0, 8'h00, 1'b1);
    nChecks++; if (bus.empty !== 1'b1) begin nFails++; $display("FAIL fwft pop empty: got %b want 1", bus.empty); end
  endtask
`endif

  task automatic test_random();
    int wrBias;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 800; n++) begin
      wrBias = ((n / 64) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < wrBias, 8'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
      nChecks++; if (bus.count !== 4'(mq.size())) begin nFails++; $display("FAIL rand count cyc %0d: got %0d want %0d", n, bus.count, mq.size()); end
      nChecks++; if (bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0)) begin nFails++; $display("FAIL rand full/empty cyc %0d: got %b/%b size %0d", n, bus.full, bus.empty, mq.size()); end
      nChecks++; if (bus.almostFull !== (mq.size() >= 6) || bus.almostEmpty !== (mq.size() <= 1)) begin nFails++; $display("FAIL rand almost cyc %0d: got af=%b ae=%b size %0d", n, bus.almostFull, bus.almostEmpty, mq.size()); end
      nChecks++; if (bus.overflow !== movf || bus.underflow !== munf) begin nFails++; $display("FAIL rand errors cyc %0d: got ovf=%b unf=%b want %b %b", n, bus.overflow, bus.underflow, movf, munf); end
`ifdef SYNC_FIFO_LEVEL_FWFT_EN
      if (mq.size() != 0) begin
        nChecks++; if (bus.readData !== mq[0]) begin nFails++; $display("FAIL rand head cyc %0d: got %h want %h", n, bus.readData, mq[0]); end
      end
`else
      nChecks++; if (bus.readData !== mrd) begin nFails++; $display("FAIL rand readData cyc %0d: got %h want %h", n, bus.readData, mrd); end
`endif
    end
  endtask

  initial begin
    bus.flush = 1'b0; bus.clearErrors = 1'b0; bus.writeEnable = 1'b0;
    bus.writeData = 8'h00; bus.readEnable = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_errors();
`ifdef SYNC_FIFO_LEVEL_FWFT_EN
    test_fwft();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
